// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin grant arbiter.
// Provides requester count, index width, FSM state type and one-hot encoder.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Encode a one-hot vector to its index; lowest set bit wins if several.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter8_if.sv
// Requester-bank / select-datapath bundle for the round-robin arbiter.
// master: drives en, req; sees gnt, gnt_idx, gnt_valid, busy. slave: arbiter.
interface rr_grant_arbiter8_if;
    import arb_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             busy;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, busy
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, busy
    );

endinterface

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set req bit after ptr.
// Ports: req[7:0], ptr[2:0] in; pick_oh[7:0], pick_idx[2:0], pick_vld out.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic             found;
    logic [IDX_W-1:0] pos;

    // Offsets 1..8 from ptr; the 3-bit add wraps, so offset 8 lands on ptr
    // itself, giving the previous owner the lowest priority.
    always_comb begin
        pick_oh = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = ptr + IDX_W'(k);
            if (!found && req[pos]) begin
                pick_oh[pos] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign pick_idx = onehot_to_idx(pick_oh);
    assign pick_vld = |req;

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter: registered one-hot grant + index, held until release.
// Ports: clk, rst (async high), bus (slave). Optional macro ARB_HOLD_LIMIT_EN.
module rr_grant_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_grant_arbiter8_if.slave   bus
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [IDX_W-1:0] search_ptr;
    logic             release_w;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Forced release looks exactly like the owner dropping its request.
    assign release_w = !bus.req[idx_q] || (cnt_q == CNT_W'(HOLD_MAX - 1));
`else
    assign release_w = !bus.req[idx_q];
`endif

    // At handover the old owner becomes the pointer in the same edge.
    assign search_ptr = (state_q == GRANT) ? idx_q : ptr_q;

    rr_pick8 u_pick (
        .req      (bus.req),
        .ptr      (search_ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
`ifdef ARB_HOLD_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.en && pick_vld) begin
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    state_d = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (release_w) begin
                    ptr_d = idx_q;
                    if (bus.en && pick_vld) begin
                        gnt_d = pick_oh;
                        idx_d = pick_idx;
`ifdef ARB_HOLD_LIMIT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        gnt_d   = '0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            gnt_q   <= '0;
            idx_q   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Scoreboard bench for rr_grant_arbiter8: directed vectors push expectations,
// a monitor pops one per clock and also checks grant invariants every cycle.
module tb_rr_grant_arbiter8;

    logic clk;
    logic rst;

    rr_grant_arbiter8_if bus ();

    rr_grant_arbiter8 #(
        .HOLD_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic       vld;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string name, input logic vld,
                             input logic [2:0] idx);
        logic [7:0] eg;
        eg = vld ? (8'h01 << idx) : 8'h00;
        n_tests++;
        if (bus.gnt !== eg || bus.gnt_idx !== (vld ? idx : 3'd0) ||
            bus.gnt_valid !== vld || bus.busy !== vld) begin
            n_fail++;
            $display("FAIL %s: gnt=%h idx=%0d valid=%b busy=%b, expected gnt=%h idx=%0d valid=%b",
                     name, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.busy,
                     eg, vld ? idx : 3'd0, vld);
        end
    endtask

    // Drive one cycle of inputs; expectation is for outputs after the next edge.
    task automatic step(input string name, input logic [7:0] r, input logic e,
                        input logic vld, input logic [2:0] idx);
        exp_t x;
        @(negedge clk);
        bus.req = r;
        bus.en  = e;
        x.name  = name;
        x.vld   = vld;
        x.idx   = idx;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        bus.en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: scoreboard pop plus per-cycle invariants.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                check_out(x.name, x.vld, x.idx);
            end
            begin
                logic [2:0] enc;
                int         cnt;
                enc = 3'd0;
                cnt = 0;
                for (int i = 7; i >= 0; i--) begin
                    if (bus.gnt[i]) begin
                        enc = 3'(i);
                        cnt++;
                    end
                end
                n_tests++;
                if (cnt > 1 || bus.gnt_valid !== (cnt == 1) ||
                    bus.gnt_idx !== enc) begin
                    n_fail++;
                    $display("FAIL invariant: gnt=%h idx=%0d valid=%b, expected one-hot idx=%0d valid=%b",
                             bus.gnt, bus.gnt_idx, bus.gnt_valid, enc, cnt == 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.en  = 1'b0;
        @(negedge clk);
        check_out("reset", 1'b0, 3'd0);
        rst = 1'b0;

        // Single request and release.
        step("idle",     8'h00, 1'b1, 1'b0, 3'd0);
        step("single",   8'h20, 1'b1, 1'b1, 3'd5);
        step("single_h", 8'h20, 1'b1, 1'b1, 3'd5);
        step("single_r", 8'h00, 1'b1, 1'b0, 3'd0);

        // Fair rotation: each owner drops its bit for one cycle.
        do_reset();
        step("rot0", 8'hFF, 1'b1, 1'b1, 3'd0);
        for (int k = 1; k <= 8; k++) begin
            logic [7:0] m;
            m = 8'h01 << (k - 1);
            step($sformatf("rot%0d", k), 8'hFF & ~m, 1'b1, 1'b1, 3'(k % 8));
        end
        step("rot_end", 8'h00, 1'b1, 1'b0, 3'd0);

        // Tie after release from owner 3.
        step("tie3",   8'h08, 1'b1, 1'b1, 3'd3);
        step("tie3_h", 8'h08, 1'b1, 1'b1, 3'd3);
        step("tie7",   8'h81, 1'b1, 1'b1, 3'd7);
        step("tie0",   8'h01, 1'b1, 1'b1, 3'd0);
        step("tie_r",  8'h00, 1'b1, 1'b0, 3'd0);

        // Enable gating never revokes, only blocks.
        step("en_g2",   8'h04, 1'b1, 1'b1, 3'd2);
        step("en_hold", 8'h06, 1'b0, 1'b1, 3'd2);
        step("en_hld2", 8'h06, 1'b0, 1'b1, 3'd2);
        step("en_rel",  8'h02, 1'b0, 1'b0, 3'd0);
        step("en_blk",  8'h02, 1'b0, 1'b0, 3'd0);
        step("en_up",   8'h02, 1'b1, 1'b1, 3'd1);
        step("en_end",  8'h00, 1'b1, 1'b0, 3'd0);

        // Async reset mid-grant clears outputs before any edge.
        step("ar_g4", 8'h10, 1'b1, 1'b1, 3'd4);
        step("ar_h4", 8'h10, 1'b1, 1'b1, 3'd4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 3'd0);
        @(negedge clk);
        rst     = 1'b0;
        bus.req = '0;
        step("ar_ptr", 8'hFF, 1'b1, 1'b1, 3'd0);
        step("ar_end", 8'h00, 1'b1, 1'b0, 3'd0);

        // Hold limit behaviour with constant req=0x03.
        do_reset();
        for (int k = 0; k < 12; k++) begin
`ifdef ARB_HOLD_LIMIT_EN
            step($sformatf("hold%0d", k), 8'h03, 1'b1, 1'b1, 3'((k / 4) % 2));
`else
            step($sformatf("hold%0d", k), 8'h03, 1'b1, 1'b1, 3'd0);
`endif
        end
        step("hold_end", 8'h00, 1'b1, 1'b0, 3'd0);

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
